frame_packetizer: RTL

- Upstream feeder for the edge-detection multi_dataflow core (Sobel/Roberts).
- Takes a frame-size command and a raw pixel stream, then emits exactly one size token on the core's size input.
- Follows the token with exactly size*size pixels on the core's pixel input.
- Buffers pixels in a small FIFO so input backpressure is decoupled from the core's full flags, and reports frame completion.

---
 rtl/frame_packetizer_if.sv | 35 +++
 rtl/frame_packetizer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/frame_packetizer_if.sv
// Handshake bundle between the frame packetizer, its pixel/config source and
// the edge-detection core. Transfer happens when wr=1 and full=0.
interface frame_packetizer_if #(
    parameter int SIZE_W = 6,
    parameter int PEL_W  = 8
);
    logic [SIZE_W-1:0] cfg_size_data;
    logic              cfg_size_wr;
    logic              cfg_size_full;
    logic [PEL_W-1:0]  in_pel_data;
    logic              in_pel_wr;
    logic              in_pel_full;
    logic [SIZE_W-1:0] out_size_data;
    logic              out_size_wr;
    logic              out_size_full;
    logic [PEL_W-1:0]  out_pel_data;
    logic              out_pel_wr;
    logic              out_pel_full;

    // Environment side: drives config and pixels, plays the core's full flags.
    modport master (
        output cfg_size_data, cfg_size_wr, in_pel_data, in_pel_wr,
        output out_size_full, out_pel_full,
        input  cfg_size_full, in_pel_full,
        input  out_size_data, out_size_wr, out_pel_data, out_pel_wr
    );

    // Packetizer side.
    modport slave (
        input  cfg_size_data, cfg_size_wr, in_pel_data, in_pel_wr,
        input  out_size_full, out_pel_full,
        output cfg_size_full, in_pel_full,
        output out_size_data, out_size_wr, out_pel_data, out_pel_wr
    );
endinterface

// File: rtl/frame_packetizer.sv
// Frame packetizer: emits one size token then size*size buffered pixels to the core.
// Optional sticky protocol-error flag when FRAME_PACKETIZER_ERR_EN is defined.
module frame_packetizer #(
    parameter int SIZE_W     = 6,
    parameter int PEL_W      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    frame_packetizer_if.slave     bus,
    output logic                  frame_done,
    output logic [2*SIZE_W-1:0]   pel_count
`ifdef FRAME_PACKETIZER_ERR_EN
    ,
    output logic                  err
`endif
);
    localparam int CW    = 2 * SIZE_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, HDR, PIX} state_t;

    state_t                state_reg, state_next;
    logic [SIZE_W-1:0]     size_reg;
    logic [CW-1:0]         total_reg;
    logic [CW-1:0]         acc_count_reg;
    logic [CW-1:0]         pel_count_reg;
    logic                  frame_done_reg;

    logic [PEL_W-1:0]      fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]   fifo_count_reg;

    logic fifo_full, fifo_empty;
    logic cfg_xfer, cfg_ok, in_xfer, size_xfer, out_xfer, last_xfer;

    assign fifo_full  = (fifo_count_reg == (DEPTH_LOG2+1)'(DEPTH));
    assign fifo_empty = (fifo_count_reg == '0);

    assign bus.cfg_size_full = (state_reg != IDLE);
    // Full is derived from registered occupancy only, so a read never lets a write slip through.
    assign bus.in_pel_full   = (state_reg != PIX) || fifo_full || (acc_count_reg == total_reg);
    assign bus.out_size_wr   = (state_reg == HDR);
    assign bus.out_size_data = (state_reg == HDR) ? size_reg : '0;
    assign bus.out_pel_wr    = !fifo_empty && !bus.out_pel_full;
    assign bus.out_pel_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];

    assign cfg_xfer  = bus.cfg_size_wr && !bus.cfg_size_full;
    assign cfg_ok    = cfg_xfer && (bus.cfg_size_data != '0);
    assign in_xfer   = bus.in_pel_wr && !bus.in_pel_full;
    assign size_xfer = bus.out_size_wr && !bus.out_size_full;
    assign out_xfer  = bus.out_pel_wr;
    assign last_xfer = out_xfer && ((pel_count_reg + CW'(1)) == total_reg);

    assign frame_done = frame_done_reg;
    assign pel_count  = pel_count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cfg_ok)    state_next = HDR;
            HDR:     if (size_xfer) state_next = PIX;
            PIX:     if (last_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            size_reg       <= '0;
            total_reg      <= '0;
            acc_count_reg  <= '0;
            pel_count_reg  <= '0;
            frame_done_reg <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            frame_done_reg <= last_xfer;
            if (cfg_ok) begin
                size_reg      <= bus.cfg_size_data;
                total_reg     <= CW'(bus.cfg_size_data) * CW'(bus.cfg_size_data);
                acc_count_reg <= '0;
                pel_count_reg <= '0;
            end
            if (in_xfer) begin
                wr_ptr_reg    <= wr_ptr_reg + 1'b1;
                acc_count_reg <= acc_count_reg + CW'(1);
            end
            if (out_xfer) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                pel_count_reg <= pel_count_reg + CW'(1);
            end
            case ({in_xfer, out_xfer})
                2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // Storage is not reset; discarding contents is done by clearing the pointers.
    always_ff @(posedge clock) begin
        if (in_xfer) begin
            fifo_mem[wr_ptr_reg] <= bus.in_pel_data;
        end
    end

`ifdef FRAME_PACKETIZER_ERR_EN
    logic err_reg;
    always_ff @(posedge clock) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if ((bus.in_pel_wr && bus.in_pel_full) ||
                     (bus.cfg_size_wr && bus.cfg_size_full) ||
                     (cfg_xfer && (bus.cfg_size_data == '0))) begin
            err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`endif
endmodule
